// File: rtl/biu_arb_pkg.sv
// Shared types and constants for the BIU external-bus arbiter.
// Holds FSM state encoding, requester indices, AHB idle code and the parked mux select.
package biu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

    localparam int REQ_TLB = 0;
    localparam int REQ_L1  = 1;
    localparam int REQ_EXT = 2;

    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [2:0] PARK_SEL    = 3'b010;

    // Fixed priority TLB > L1 > Ext, unless the external master has waited too long.
    function automatic logic [2:0] pick_winner(input logic [2:0] req, input logic promote_ext);
        logic [2:0] win;
        win = 3'b000;
        if (promote_ext && req[REQ_EXT]) win = 3'b100;
        else if (req[REQ_TLB])           win = 3'b001;
        else if (req[REQ_L1])            win = 3'b010;
        else if (req[REQ_EXT])           win = 3'b100;
        return win;
    endfunction

endpackage

// File: rtl/biu_arb_wait_cnt.sv
// Saturating starvation counter for the external master; clear wins over increment.
// One-cycle update, sat is a registered compare against MAX.
module biu_arb_wait_cnt #(
    parameter int MAX   = 16,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && (cnt_q != MAX_C))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign sat = (cnt_q == MAX_C);

endmodule

// File: rtl/biu_bus_arbiter.sv
// Arbitrates the single AHB master port between TLB, L1 and an external master.
// Grant one cycle after request from IDLE; ownership only moves at transfer boundaries via DRAIN.
module biu_bus_arbiter
    import biu_arb_pkg::*;
#(
    parameter int EXT_MAX_WAIT = 16,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tlb_req,
    output logic       tlb_ack,
    input  logic       l1_req,
    output logic       l1_ack,
    input  logic       ext_req,
    output logic       ext_ack,
    input  logic [1:0] htrans,
    input  logic       hready,
    input  logic       hmastlock,
    output logic [2:0] sel,
    output logic       park,
    output logic       busy
);

    arb_state_e state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [2:0] ack_q, ack_d;
    logic       park_q, park_d;
    logic       busy_q, busy_d;

    logic [2:0] req_vec;
    logic       owner_req;
    logic       ext_sat;

    assign req_vec   = {ext_req, l1_req, tlb_req};
    // sel_q is one-hot to the owner throughout GRANT, so it doubles as the owner mask.
    assign owner_req = |(req_vec & sel_q);

    biu_arb_wait_cnt #(
        .MAX   (EXT_MAX_WAIT),
        .CNT_W (CNT_W)
    ) u_wait_cnt (
        .clk (clk),
        .rst (rst),
        .inc (ext_req & ~ack_q[REQ_EXT]),
        .clr (~ext_req | ack_q[REQ_EXT]),
        .sat (ext_sat)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ack_d   = ack_q;
        park_d  = park_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_vec) begin
                    state_d = ST_GRANT;
                    sel_d   = pick_winner(req_vec, ext_sat);
                    ack_d   = sel_d;
                    park_d  = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    sel_d   = PARK_SEL;
                    ack_d   = 3'b000;
                    park_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            ST_GRANT: begin
                if (!owner_req && !hmastlock) begin
                    state_d = ST_DRAIN;
                    ack_d   = 3'b000;
                end
            end
            ST_DRAIN: begin
                // sel stays on the old owner until its final data phase is accepted.
                if (hready && (htrans == HTRANS_IDLE)) begin
                    state_d = ST_IDLE;
                    sel_d   = PARK_SEL;
                    park_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = PARK_SEL;
                ack_d   = 3'b000;
                park_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            sel_q   <= PARK_SEL;
            ack_q   <= 3'b000;
            park_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
            park_q  <= park_d;
            busy_q  <= busy_d;
        end
    end

    assign tlb_ack = ack_q[REQ_TLB];
    assign l1_ack  = ack_q[REQ_L1];
    assign ext_ack = ack_q[REQ_EXT];
    assign sel     = sel_q;
    assign park    = park_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_biu_bus_arbiter.sv
// Directed bench for biu_bus_arbiter with EXT_MAX_WAIT=4 so starvation promotion is reachable quickly.
module tb_biu_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tlb_req = 1'b0, l1_req = 1'b0, ext_req = 1'b0;
    logic       tlb_ack, l1_ack, ext_ack;
    logic [1:0] htrans = 2'b00;
    logic       hready = 1'b1;
    logic       hmastlock = 1'b0;
    logic [2:0] sel;
    logic       park, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    biu_bus_arbiter #(
        .EXT_MAX_WAIT (4),
        .CNT_W        (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tlb_req   (tlb_req),
        .tlb_ack   (tlb_ack),
        .l1_req    (l1_req),
        .l1_ack    (l1_ack),
        .ext_req   (ext_req),
        .ext_ack   (ext_ack),
        .htrans    (htrans),
        .hready    (hready),
        .hmastlock (hmastlock),
        .sel       (sel),
        .park      (park),
        .busy      (busy)
    );

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        tlb_req = 0; l1_req = 0; ext_req = 0;
        hmastlock = 0; hready = 1; htrans = 2'b00;
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst = 0;
        repeat (3) step();
        checks++;
        if ({tlb_ack, l1_ack, ext_ack, sel, park, busy} !== 8'b000_010_1_0) begin
            errors++;
            $display("FAIL reset_hold got acks=%b%b%b sel=%b park=%b busy=%b want acks=000 sel=010 park=1 busy=0",
                     tlb_ack, l1_ack, ext_ack, sel, park, busy);
        end
        rst = 1;
        repeat (2) step();
        checks++;
        if ({tlb_ack, l1_ack, ext_ack, sel, park, busy} !== 8'b000_010_1_0) begin
            errors++;
            $display("FAIL reset_idle got acks=%b%b%b sel=%b park=%b busy=%b want acks=000 sel=010 park=1 busy=0",
                     tlb_ack, l1_ack, ext_ack, sel, park, busy);
        end
        checks++;
        if (dut.u_wait_cnt.cnt_q !== 8'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d want 0", dut.u_wait_cnt.cnt_q);
        end
    endtask

    task automatic test_priority();
        tlb_req = 1; l1_req = 1; ext_req = 1;
        step();  // edge 0
        checks++;
        if ({tlb_ack, l1_ack, ext_ack, sel, park, busy} !== 8'b100_001_0_1) begin
            errors++;
            $display("FAIL prio_e0 got acks=%b%b%b sel=%b park=%b busy=%b want acks=100 sel=001 park=0 busy=1",
                     tlb_ack, l1_ack, ext_ack, sel, park, busy);
        end
        ext_req = 0;  // keep the starvation counter out of this scenario
        repeat (3) step();  // edges 1..3
        checks++;
        if ({tlb_ack, l1_ack, sel} !== 5'b10_001) begin
            errors++;
            $display("FAIL prio_hold got tlb=%b l1=%b sel=%b want tlb=1 l1=0 sel=001", tlb_ack, l1_ack, sel);
        end
        tlb_req = 0; hready = 1; htrans = 2'b00;
        step();  // edge 4
        checks++;
        if ({tlb_ack, l1_ack, ext_ack, sel, park, busy} !== 8'b000_001_0_1) begin
            errors++;
            $display("FAIL prio_e4_drain got acks=%b%b%b sel=%b park=%b busy=%b want acks=000 sel=001 park=0 busy=1",
                     tlb_ack, l1_ack, ext_ack, sel, park, busy);
        end
        step();  // edge 5
        checks++;
        if ({tlb_ack, l1_ack, ext_ack, sel, park, busy} !== 8'b000_010_1_0) begin
            errors++;
            $display("FAIL prio_e5_idle got acks=%b%b%b sel=%b park=%b busy=%b want acks=000 sel=010 park=1 busy=0",
                     tlb_ack, l1_ack, ext_ack, sel, park, busy);
        end
        step();  // edge 6
        checks++;
        if ({tlb_ack, l1_ack, ext_ack, sel, park} !== 7'b010_010_0) begin
            errors++;
            $display("FAIL prio_e6_l1 got acks=%b%b%b sel=%b park=%b want acks=010 sel=010 park=0",
                     tlb_ack, l1_ack, ext_ack, sel, park);
        end
        settle();
    endtask

    task automatic test_lock_hold();
        l1_req = 1;
        step();
        checks++;
        if (l1_ack !== 1'b1) begin
            errors++;
            $display("FAIL lock_grant got l1_ack=%b want 1", l1_ack);
        end
        l1_req = 0; hmastlock = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({l1_ack, sel, park, busy} !== 6'b1_010_0_1) begin
                errors++;
                $display("FAIL lock_hold[%0d] got l1_ack=%b sel=%b park=%b busy=%b want l1_ack=1 sel=010 park=0 busy=1",
                         i, l1_ack, sel, park, busy);
            end
        end
        hmastlock = 0;
        step();
        checks++;
        if ({l1_ack, sel, park, busy} !== 6'b0_010_0_1) begin
            errors++;
            $display("FAIL lock_release got l1_ack=%b sel=%b park=%b busy=%b want l1_ack=0 sel=010 park=0 busy=1",
                     l1_ack, sel, park, busy);
        end
        step();
        checks++;
        if ({park, busy} !== 2'b10) begin
            errors++;
            $display("FAIL lock_idle got park=%b busy=%b want park=1 busy=0", park, busy);
        end
        settle();
    endtask

    task automatic test_drain_wait();
        tlb_req = 1;
        step();
        tlb_req = 0; l1_req = 1; hready = 0; htrans = 2'b10;
        step();
        for (int i = 0; i < 7; i++) begin
            checks++;
            if ({tlb_ack, l1_ack, ext_ack, sel, park, busy} !== 8'b000_001_0_1) begin
                errors++;
                $display("FAIL drain_hold[%0d] got acks=%b%b%b sel=%b park=%b busy=%b want acks=000 sel=001 park=0 busy=1",
                         i, tlb_ack, l1_ack, ext_ack, sel, park, busy);
            end
            step();
        end
        // hready alone is not enough while a transfer is still signalled
        hready = 1; htrans = 2'b10;
        step();
        checks++;
        if ({sel, park} !== 4'b001_0) begin
            errors++;
            $display("FAIL drain_busy_htrans got sel=%b park=%b want sel=001 park=0", sel, park);
        end
        htrans = 2'b00;
        step();
        checks++;
        if ({tlb_ack, l1_ack, ext_ack, sel, park} !== 7'b000_010_1) begin
            errors++;
            $display("FAIL drain_to_idle got acks=%b%b%b sel=%b park=%b want acks=000 sel=010 park=1",
                     tlb_ack, l1_ack, ext_ack, sel, park);
        end
        step();
        checks++;
        if ({l1_ack, sel} !== 4'b1_010) begin
            errors++;
            $display("FAIL drain_next_grant got l1_ack=%b sel=%b want l1_ack=1 sel=010", l1_ack, sel);
        end
        settle();
    endtask

    task automatic test_starvation();
        tlb_req = 1; l1_req = 1; ext_req = 1;
        step();  // e0: tlb wins, cnt=1
        checks++;
        if (tlb_ack !== 1'b1) begin
            errors++;
            $display("FAIL starve_tlb got tlb_ack=%b want 1", tlb_ack);
        end
        tlb_req = 0;
        step();  // e1: drain, cnt=2
        step();  // e2: idle, cnt=3
        step();  // e3: decision with cnt=3 -> l1, cnt=4
        checks++;
        if ({tlb_ack, l1_ack, ext_ack} !== 3'b010) begin
            errors++;
            $display("FAIL starve_l1_before_sat got acks=%b%b%b want 010", tlb_ack, l1_ack, ext_ack);
        end
        checks++;
        if (dut.u_wait_cnt.cnt_q !== 8'd4) begin
            errors++;
            $display("FAIL starve_cnt_sat got %0d want 4", dut.u_wait_cnt.cnt_q);
        end
        tlb_req = 1; l1_req = 0;
        step();  // e4: drain
        step();  // e5: idle
        step();  // e6: promoted ext beats tlb
        checks++;
        if ({tlb_ack, l1_ack, ext_ack, sel} !== 6'b001_100) begin
            errors++;
            $display("FAIL starve_ext_promoted got acks=%b%b%b sel=%b want acks=001 sel=100",
                     tlb_ack, l1_ack, ext_ack, sel);
        end
        step();  // e7: cleared by ext_ack
        checks++;
        if (dut.u_wait_cnt.cnt_q !== 8'd0) begin
            errors++;
            $display("FAIL starve_cnt_clear got %0d want 0", dut.u_wait_cnt.cnt_q);
        end
        settle();
    endtask

    task automatic test_async_reset();
        ext_req = 1;
        step();
        checks++;
        if ({ext_ack, sel} !== 4'b1_100) begin
            errors++;
            $display("FAIL areset_pre got ext_ack=%b sel=%b want ext_ack=1 sel=100", ext_ack, sel);
        end
        #2 rst = 0;
        #1;
        checks++;
        if ({tlb_ack, l1_ack, ext_ack, sel, park, busy} !== 8'b000_010_1_0) begin
            errors++;
            $display("FAIL areset_mid got acks=%b%b%b sel=%b park=%b busy=%b want acks=000 sel=010 park=1 busy=0",
                     tlb_ack, l1_ack, ext_ack, sel, park, busy);
        end
        #2 rst = 1;
        ext_req = 0;
        settle();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_lock_hold();
        test_drain_wait();
        test_starvation();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/biu_bus_arbiter.md
# biu_bus_arbiter

Sequential arbiter for the single external AHB master port of the BIU. It shares the port between the TLB bus unit (page walks and PTE write-back), the L1 cache bus unit (line fills, single reads, write-through), and an external bus master. It issues level req/ack grants and a one-hot select that steers the AHB mux. Grants only change at transfer boundaries, and a starvation counter keeps the external master from being locked out by internal traffic.

## Interface
- EXT_MAX_WAIT, 16: cycles an external request may wait before it is promoted above internal requesters (legal 1..255).
- CNT_W, 8: width of the starvation counter; must hold EXT_MAX_WAIT.

- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- tlb_req  in  1  TLB bus unit requests the bus (level).
- tlb_ack  out  1  bus granted to the TLB bus unit.
- l1_req  in  1  L1 bus unit requests the bus (level).
- l1_ack  out  1  bus granted to the L1 bus unit.
- ext_req  in  1  external master requests the bus (level).
- ext_ack  out  1  bus granted to the external master.
- htrans  in  2  muxed AHB htrans of the current owner.
- hready  in  1  AHB hready.
- hmastlock  in  1  muxed AHB hmastlock of the current owner.
- sel  out  3  one-hot mux select: [0]=TLB, [1]=L1, [2]=Ext.
- park  out  1  no owner; the mux must drive htrans=IDLE.
- busy  out  1  FSM not in IDLE.

## Operation
- FSM states: IDLE, GRANT, DRAIN. All outputs come from registers.
- IDLE: if any request is pending, latch the winner and go to GRANT. Otherwise stay, with sel=3'b010 (parked on L1) and park=1.
- Winner priority:
  - ext, if the starvation counter equals EXT_MAX_WAIT;
  - otherwise tlb > l1 > ext.
- GRANT: the owner's ack is 1 and sel is one-hot to the owner.
  - Stay while owner_req=1 or hmastlock=1.
  - Otherwise go to DRAIN with all acks at 0.
  - Requests from other masters are ignored in this state. There is no preemption.
- DRAIN: sel is held on the old owner so its last data phase completes.
  - Go to IDLE when hready=1 and htrans==IDLE (2'b00).
  - While in DRAIN, park=0 and acks=0.
- Starvation counter:
  - Increments each cycle that ext_req=1 and ext_ack=0, saturating at EXT_MAX_WAIT.
  - Clears when ext_ack=1 or ext_req=0.
- A requester dropping req in the same cycle it wins in IDLE still receives GRANT. It then leaves on the next evaluation (GRANT→DRAIN).
- A simultaneous drop of owner_req and assertion of hmastlock keeps GRANT.
- hresp is not an input: error responses never change ownership.
- Asynchronous reset at any point gives:
  - state=IDLE, all acks=0, sel=3'b010, park=1, busy=0, counter=0.
  - An in-flight transfer is abandoned. The bus unit resets on the same reset.

## Timing
- Request to ack latency from IDLE is one cycle. req is sampled high at edge N, and ack is high after edge N.
- Release to next grant:
  - owner_req drops and is sampled at edge N; ack falls after N (DRAIN).
  - With hready=1 and htrans=IDLE at edge N+1, the FSM is in IDLE after N+1.
  - The new ack is high after N+2. The minimum gap is 2 cycles with no ack.
- DRAIN has no upper bound. It waits on hready indefinitely.
- The starvation counter compares at the IDLE decision edge. Promotion takes effect at the first IDLE after the counter saturates.
- Exactly one of {tlb_ack, l1_ack, ext_ack} is high in GRANT, and none in IDLE/DRAIN. sel is always one-hot.

## Structure
- Package biu_arb_pkg:
  - state encoding constants ST_IDLE/ST_GRANT/ST_DRAIN;
  - requester indices REQ_TLB=0, REQ_L1=1, REQ_EXT=2;
  - HTRANS_IDLE=2'b00;
  - PARK_SEL=3'b010.
- One sub-module is natural: biu_arb_wait_cnt, the saturating starvation counter (inputs inc/clr, output sat).
- Everything else is flat in biu_bus_arbiter.

## Test plan
- Reset, then idle: rst low for 3 cycles, then high with no reqs → acks=0, sel=3'b010, park=1, busy=0.
- Priority: tlb_req, l1_req and ext_req all rise at edge 0 →
  - tlb_ack=1 after edge 0;
  - drop tlb_req at edge 4 with hready=1 and htrans=0 → tlb_ack=0 after 4, l1_ack=1 after edge 6.
- Lock hold: L1 owner drops l1_req while hmastlock=1 for 5 cycles → l1_ack stays 1, and no DRAIN until hmastlock=0.
- Drain wait: owner releases while hready=0 for 7 cycles → sel is held on the owner, acks=0, and the next grant comes 2 cycles after hready=1 with htrans=IDLE.
- Starvation (EXT_MAX_WAIT=4): ext_req held while the TLB and L1 alternate long grants → after the counter saturates, ext wins the next IDLE decision even with tlb_req=1, and the counter reads 0 after ext_ack.
- Async reset mid-GRANT: rst pulsed low between edges while ext_ack=1 → ext_ack falls immediately and sel=3'b010 with no clock edge needed.
